// File: rtl/shift_lr_if.sv
// shift_lr_if
// Groups the operand, control and result signals of the 32-bit barrel
// shifter into one bundle.
//   X    : operand to be shifted (32 bits)
//   S    : unsigned shift amount, 0..31 (5 bits)
//   LEFT : 1 = shift left, 0 = shift right
//   LOG  : right-shift type, 1 = logical, 0 = arithmetic (ignored on left)
//   Z    : registered shift result (32 bits)
// The master modport drives the operation and reads Z.
// The slave modport is the shifter itself.
interface shift_lr_if;
   logic [31:0] X;
   logic [4:0]  S;
   logic        LEFT;
   logic        LOG;
   logic [31:0] Z;

   modport master (output X, output S, output LEFT, output LOG, input Z);
   modport slave  (input X, input S, input LEFT, input LOG, output Z);
endinterface

// File: rtl/shift_lr.sv
// shift_lr
// A 32-bit logarithmic barrel shifter with a one-cycle registered result.
// It performs a left shift, a logical right shift or an arithmetic right
// shift. A new operation is accepted on every rising clock edge.
//   clk : single clock, rising-edge active
//   rst : asynchronous, active-high reset; clears Z immediately
//   bus : shift_lr_if slave modport (X, S, LEFT, LOG in; Z out)
module shift_lr (
   input  logic       clk,
   input  logic       rst,
   shift_lr_if.slave  bus
);

   logic        fill;
   logic [31:0] stage_in;
   logic [31:0] stage1;
   logic [31:0] stage2;
   logic [31:0] stage4;
   logic [31:0] stage8;
   logic [31:0] stage16;
   logic [31:0] result;

   // Mirror the bit order so the right-shift stages can also perform a left shift.
   function automatic logic [31:0] bit_reverse(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // Only the right-shift stages exist. A left shift reverses the operand
   // going in and reverses the result coming out. The fill bit is the sign
   // bit only for an arithmetic right shift; every other mode shifts in zeros.
   always_comb begin
      fill     = !bus.LEFT && !bus.LOG && bus.X[31];
      stage_in = bus.LEFT ? bit_reverse(bus.X) : bus.X;
      stage1   = bus.S[0] ? {fill, stage_in[31:1]}          : stage_in;
      stage2   = bus.S[1] ? {{2{fill}}, stage1[31:2]}       : stage1;
      stage4   = bus.S[2] ? {{4{fill}}, stage2[31:4]}       : stage2;
      stage8   = bus.S[3] ? {{8{fill}}, stage4[31:8]}       : stage4;
      stage16  = bus.S[4] ? {{16{fill}}, stage8[31:16]}     : stage8;
      result   = bus.LEFT ? bit_reverse(stage16) : stage16;
   end

   // The result register is the block's only state. Reset clears it at once,
   // which also discards any operation that is still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.Z <= 32'h0000_0000;
      end else begin
         bus.Z <= result;
      end
   end

endmodule

// File: tb/tb_shift_lr.sv
// tb_shift_lr
// Testbench for shift_lr. It runs directed boundary cases, an asynchronous
// reset in the middle of a stream, and a randomized regression. Every
// result is compared with a reference built from the language shift
// operators.
module tb_shift_lr;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   shift_lr_if bus ();

   shift_lr dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10-time-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference result, computed directly from the shift operators.
   function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s,
                                             input logic left, input logic log_mode);
      if (left)          return x << s;
      else if (log_mode) return x >> s;
      else               return 32'($signed(x) >>> s);
   endfunction

   // Present one operation and step past the edge that captures it.
   task automatic applyStimulus(input logic [31:0] x, input logic [4:0] s,
                                input logic left, input logic log_mode);
      bus.X    = x;
      bus.S    = s;
      bus.LEFT = left;
      bus.LOG  = log_mode;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] expected);
      checks++;
      assert (bus.Z === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, bus.Z, expected);
      end
   endtask

   initial begin
      logic [31:0] rx;
      logic [4:0]  rs;
      logic        rleft;
      logic        rlog;
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      bus.X    = 32'h0;
      bus.S    = 5'd0;
      bus.LEFT = 1'b0;
      bus.LOG  = 1'b0;

      // Reset takes effect before any clock edge and holds across edges.
      #1 rst = 1'b1;
      #1;
      checkOutput("reset_async", 32'h0);
      applyStimulus(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1);
      checkOutput("reset_hold", 32'h0);
      #2 rst = 1'b0;

      // Directed cases.
      applyStimulus(32'h8000_0001, 5'd1, 1'b1, 1'b0);
      checkOutput("left_s1", 32'h0000_0002);
      applyStimulus(32'h8000_0000, 5'd31, 1'b0, 1'b1);
      checkOutput("lsr_s31", 32'h0000_0001);
      applyStimulus(32'h8000_0000, 5'd31, 1'b0, 1'b0);
      checkOutput("asr_neg_s31", 32'hFFFF_FFFF);
      applyStimulus(32'h7FFF_FFFF, 5'd4, 1'b0, 1'b0);
      checkOutput("asr_pos_s4", 32'h07FF_FFFF);
      applyStimulus(32'hDEAD_BEEF, 5'd31, 1'b1, 1'b1);
      checkOutput("left_s31_log_ignored", 32'h8000_0000);
      applyStimulus(32'h1234_5678, 5'd16, 1'b1, 1'b0);
      checkOutput("left_s16", 32'h5678_0000);
      applyStimulus(32'hF0F0_1234, 5'd8, 1'b0, 1'b0);
      checkOutput("asr_s8", 32'hFFF0_F012);
      applyStimulus(32'hF0F0_1234, 5'd8, 1'b0, 1'b1);
      checkOutput("lsr_s8", 32'h00F0_F012);
      applyStimulus(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0);
      checkOutput("zero_left", 32'hDEAD_BEEF);
      applyStimulus(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1);
      checkOutput("zero_lsr", 32'hDEAD_BEEF);
      applyStimulus(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
      checkOutput("zero_asr", 32'hDEAD_BEEF);

      // Reset pulse between edges while Z holds DEADBEEF.
      #2 rst = 1'b1;
      #1;
      checkOutput("reset_midstream", 32'h0);
      #1 rst = 1'b0;
      applyStimulus(32'h1234_5678, 5'd4, 1'b1, 1'b0);
      checkOutput("after_reset_first_edge", 32'h2345_6780);

      // Random regression that cycles left, logical right and arithmetic right.
      // It stops at the first mismatch.
      for (int i = 0; i < 300; i++) begin
         rx    = $urandom;
         rs    = 5'($urandom_range(0, 31));
         rleft = (i % 3) == 0;
         rlog  = rleft ? 1'($urandom) : ((i % 3) == 1);
         applyStimulus(rx, rs, rleft, rlog);
         checkOutput("random", ref_shift(rx, rs, rleft, rlog));
         if (errors != 0) break;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_lr.md
SHIFT_LR -- requirements
Module: shift_lr

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift-amount width at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 X  input  32  operand to be shifted.
REQ-005 S  input  5  shift amount, unsigned, 0..31.
REQ-006 LEFT  input  1  direction: 1 = shift left, 0 = shift right.
REQ-007 LOG  input  1  right-shift type: 1 = logical (zero fill), 0 = arithmetic (sign fill); ignored when LEFT=1.
REQ-008 Z  output  32  registered shift result.

Function
REQ-009 The block SHALL sample X, S, LEFT and LOG on each rising clk edge while rst=0, and load the corresponding result into Z on that same edge.
- Latency: exactly 1 cycle.
- Throughput: one new operation per cycle.
- No handshake; every edge is a valid operation.
REQ-010 LEFT=1 SHALL produce Z = X << S (logical left, zero fill, truncated to 32 bits), regardless of LOG.
REQ-011 LEFT=0, LOG=1 SHALL produce Z = X >> S with zero fill of the upper S bits.
REQ-012 LEFT=0, LOG=0 SHALL produce the arithmetic right shift of X by S, with the upper S bits filled with X[31].
REQ-013 S=0 SHALL pass X to Z unchanged in all three modes.
REQ-014 S=31 SHALL be supported as follows:
- left: Z = {X[0], 31'b0}
- logical right: Z = {31'b0, X[31]}
- arithmetic right: Z = 32 copies of X[31]
REQ-015 The shift datapath SHALL be a logarithmic barrel shifter of 5 mux stages (shift by 1, 2, 4, 8, 16), each stage controlled by one bit of S.
- Left shifts SHALL reuse the right-shift stages by bit-reversing the operand in and out.
- Fill bit: 0 for left and logical right; X[31] for arithmetic right.
REQ-016 The combinational path from X, S, LEFT and LOG to the Z register SHALL contain no latches and no feedback.
REQ-017 Z SHALL be a pure function of the inputs sampled at the previous edge; there is no other internal state.
REQ-018 Z SHALL never contain X or Z (unknown/high-impedance) values when all inputs are known.

Reset
REQ-019 While rst=1, Z SHALL be 32'h0000_0000; assertion clears Z immediately, independent of clk.
REQ-020 Assertion of rst in the middle of a stream SHALL discard the in-flight result.
REQ-021 The first rising clk edge with rst=0 after deassertion SHALL load the result for the inputs present at that edge.

Verification
REQ-022 Left shift: LEFT=1, LOG=0, X=32'h8000_0001, S=1 -> Z=32'h0000_0002 after one edge.
REQ-023 Logical right, maximum shift: LEFT=0, LOG=1, X=32'h8000_0000, S=31 -> Z=32'h0000_0001.
REQ-024 Arithmetic right, negative and positive operands:
- LEFT=0, LOG=0, X=32'h8000_0000, S=31 -> Z=32'hFFFF_FFFF
- X=32'h7FFF_FFFF, S=4 -> Z=32'h07FF_FFFF
REQ-025 Zero shift: X=32'hDEAD_BEEF, S=0, each of the three modes -> Z=32'hDEAD_BEEF.
REQ-026 Reset mid-stream: with Z=32'hDEAD_BEEF, pulse rst=1 between edges -> Z=32'h0 immediately; the first edge after release loads the new result.
REQ-027 Random regression: random X and S on every edge, cycling through all three modes.
- Each Z SHALL equal the Verilog <<, >> or >>> reference of the previous cycle's inputs.
- Any mismatch stops the run.
